// File: rtl/mc_control_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : mc_control_unit_if
//  Purpose  : Control-unit <-> multi-cycle datapath signal bundle.
//  Revision : 1.0  initial release
// ============================================================================
interface mc_control_unit_if #(
    parameter int OPCODE_W = 4,
    parameter int CNT_W    = 16
);
    logic [OPCODE_W-1:0] opcode;
    logic                zero;
    logic                mem_ready;

    logic                pc_write;
    logic                i_or_d;
    logic                mem_read;
    logic                mem_write;
    logic                ir_write;
    logic                reg_write;
    logic                mem_to_reg;
    logic                reg_dest;
    logic                alu_src_a;
    logic [1:0]          alu_src_b;
    logic [2:0]          alu_op;
    logic                pc_source;
    logic [3:0]          state;
    logic                instr_done;
    logic [CNT_W-1:0]    instret;
    logic                illegal_op;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, i_or_d, mem_read, mem_write, ir_write, reg_write,
               mem_to_reg, reg_dest, alu_src_a, alu_src_b, alu_op, pc_source,
               state, instr_done, instret, illegal_op
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, i_or_d, mem_read, mem_write, ir_write, reg_write,
               mem_to_reg, reg_dest, alu_src_a, alu_src_b, alu_op, pc_source,
               state, instr_done, instret, illegal_op
    );
endinterface
`default_nettype wire

// File: rtl/mc_control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mc_control_unit
//  Purpose  : Multi-cycle MIPS control FSM with memory-ready handshake,
//             retired-instruction counter and optional illegal-opcode trap
//             (enabled by defining ILLEGAL_TRAP_EN).
//  Revision : 1.0  initial release
// ============================================================================
module mc_control_unit #(
    parameter int OPCODE_W = 4,
    parameter int CNT_W    = 16
) (
    input wire                clk,
    input wire                reset,
    mc_control_unit_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADDR  = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC     = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_TRAP     = 4'd9
    } state_t;

    localparam logic [3:0] c_op_r    = 4'd0;
    localparam logic [3:0] c_op_addi = 4'd1;
    localparam logic [3:0] c_op_andi = 4'd2;
    localparam logic [3:0] c_op_ori  = 4'd3;
    localparam logic [3:0] c_op_nori = 4'd4;
    localparam logic [3:0] c_op_beq  = 4'd5;
    localparam logic [3:0] c_op_bne  = 4'd6;
    localparam logic [3:0] c_op_slti = 4'd7;
    localparam logic [3:0] c_op_lw   = 4'd8;
    localparam logic [3:0] c_op_sw   = 4'd9;

    state_t           state_q, state_d;
    logic [3:0]       opcode_q, opcode_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             w_hi_bits_set;
    logic             w_illegal;
    logic             w_instr_done;

    generate
        if (OPCODE_W > 4) begin : g_wide_opcode
            assign w_hi_bits_set = |bus.opcode[OPCODE_W-1:4];
        end else begin : g_narrow_opcode
            assign w_hi_bits_set = 1'b0;
        end
    endgenerate

    assign w_illegal = w_hi_bits_set || (bus.opcode[3:0] > c_op_sw);

`ifdef ILLEGAL_TRAP_EN
    logic illegal_op_q, illegal_op_d;
`endif

    always_comb begin
        state_d        = state_q;
        opcode_d       = opcode_q;
        w_instr_done   = 1'b0;
        bus.pc_write   = 1'b0;
        bus.i_or_d     = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.ir_write   = 1'b0;
        bus.reg_write  = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.reg_dest   = 1'b0;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = 2'b00;
        bus.alu_op     = 3'b000;
        bus.pc_source  = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        illegal_op_d   = illegal_op_q;
`endif
        case (state_q)
            S_FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = 2'b01;
                // Load enables must stay quiet while reset is held.
                bus.ir_write  = bus.mem_ready & ~reset;
                bus.pc_write  = bus.mem_ready & ~reset;
                if (bus.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                bus.alu_src_b = 2'b11;
                opcode_d      = bus.opcode[3:0];
                if (w_illegal) begin
`ifdef ILLEGAL_TRAP_EN
                    state_d      = S_TRAP;
                    illegal_op_d = 1'b1;
`else
                    state_d      = S_FETCH;
                    w_instr_done = 1'b1;
`endif
                end else if (bus.opcode[3:0] == c_op_lw || bus.opcode[3:0] == c_op_sw) begin
                    state_d = S_MEMADDR;
                end else if (bus.opcode[3:0] == c_op_beq || bus.opcode[3:0] == c_op_bne) begin
                    state_d = S_BRANCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_MEMADDR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                state_d       = (opcode_q == c_op_lw) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                bus.i_or_d   = 1'b1;
                bus.mem_read = 1'b1;
                if (bus.mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
                w_instr_done   = 1'b1;
                state_d        = S_FETCH;
            end
            S_MEMWRITE: begin
                bus.i_or_d    = 1'b1;
                bus.mem_write = 1'b1;
                if (bus.mem_ready) begin
                    w_instr_done = 1'b1;
                    state_d      = S_FETCH;
                end
            end
            S_EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = (opcode_q == c_op_r) ? 2'b00 : 2'b10;
                case (opcode_q)
                    c_op_r:    bus.alu_op = 3'b001;
                    c_op_addi: bus.alu_op = 3'b000;
                    c_op_andi: bus.alu_op = 3'b110;
                    c_op_ori:  bus.alu_op = 3'b111;
                    c_op_nori: bus.alu_op = 3'b101;
                    c_op_slti: bus.alu_op = 3'b100;
                    default:   bus.alu_op = 3'b000;
                endcase
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                bus.reg_write = 1'b1;
                bus.reg_dest  = (opcode_q == c_op_r);
                w_instr_done  = 1'b1;
                state_d       = S_FETCH;
            end
            S_BRANCH: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = 3'b010;
                bus.pc_source = 1'b1;
                bus.pc_write  = (opcode_q == c_op_beq) ? bus.zero : ~bus.zero;
                w_instr_done  = 1'b1;
                state_d       = S_FETCH;
            end
`ifdef ILLEGAL_TRAP_EN
            S_TRAP: state_d = S_TRAP;
`endif
            default: state_d = S_FETCH;
        endcase
        instret_d = w_instr_done ? instret_q + CNT_W'(1) : instret_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            opcode_q  <= 4'd0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            instret_q <= instret_d;
        end
    end

`ifdef ILLEGAL_TRAP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) illegal_op_q <= 1'b0;
        else       illegal_op_q <= illegal_op_d;
    end
    assign bus.illegal_op = illegal_op_q;
`else
    assign bus.illegal_op = 1'b0;
`endif

    assign bus.state      = state_q;
    assign bus.instr_done = w_instr_done;
    assign bus.instret    = instret_q;
endmodule
`default_nettype wire

// File: tb/tb_mc_control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mc_control_unit
//  Purpose  : Self-checking bench: two instances (6-bit opcode / 16-bit
//             counter and 4-bit opcode / 2-bit counter) against a per-
//             instruction phase model. Honours ILLEGAL_TRAP_EN.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mc_control_unit;
    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    int         n_tests = 0;
    int         n_fail  = 0;
    int         retired = 0;

    always #5 clk = ~clk;

    mc_control_unit_if #(.OPCODE_W(6), .CNT_W(16)) bus_a ();
    mc_control_unit_if #(.OPCODE_W(4), .CNT_W(2))  bus_b ();

    assign bus_a.opcode    = opcode;
    assign bus_a.zero      = zero;
    assign bus_a.mem_ready = mem_ready;
    assign bus_b.opcode    = opcode[3:0];
    assign bus_b.zero      = zero;
    assign bus_b.mem_ready = mem_ready;

    mc_control_unit #(.OPCODE_W(6), .CNT_W(16)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    mc_control_unit #(.OPCODE_W(4), .CNT_W(2))  dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    logic [14:0] ctl_a, ctl_b;
    assign ctl_a = {bus_a.pc_write, bus_a.i_or_d, bus_a.mem_read, bus_a.mem_write, bus_a.ir_write,
                    bus_a.reg_write, bus_a.mem_to_reg, bus_a.reg_dest, bus_a.alu_src_a,
                    bus_a.alu_src_b, bus_a.alu_op, bus_a.pc_source};
    assign ctl_b = {bus_b.pc_write, bus_b.i_or_d, bus_b.mem_read, bus_b.mem_write, bus_b.ir_write,
                    bus_b.reg_write, bus_b.mem_to_reg, bus_b.reg_dest, bus_b.alu_src_a,
                    bus_b.alu_src_b, bus_b.alu_op, bus_b.pc_source};

    // ALU operation each opcode should request in EXEC
    logic [2:0] exec_op [0:9] = '{3'b001, 3'b000, 3'b110, 3'b111, 3'b101,
                                  3'b000, 3'b000, 3'b100, 3'b000, 3'b000};

    function automatic logic [14:0] cw(input logic pcw, input logic iod, input logic mr,
                                       input logic mw, input logic irw, input logic rw,
                                       input logic m2r, input logic rd, input logic sa,
                                       input logic [1:0] sb, input logic [2:0] op,
                                       input logic ps);
        return {pcw, iod, mr, mw, irw, rw, m2r, rd, sa, sb, op, ps};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic noise();
        opcode    = 6'($urandom);
        zero      = 1'($urandom);
        mem_ready = 1'($urandom);
    endtask

    // One clock: inputs already driven; check mid-cycle, then advance past the edge.
    task automatic step(input int es, input logic [14:0] ec, input logic ed, input logic ei);
        @(negedge clk);
        check("state_a",   32'(bus_a.state), 32'(es));
        check("state_b",   32'(bus_b.state), 32'(es));
        check("ctl_a",     32'(ctl_a), 32'(ec));
        check("ctl_b",     32'(ctl_b), 32'(ec));
        check("done_a",    32'(bus_a.instr_done), 32'(ed));
        check("done_b",    32'(bus_b.instr_done), 32'(ed));
        check("instret_a", 32'(bus_a.instret), 32'(retired & 32'hFFFF));
        check("instret_b", 32'(bus_b.instret), 32'(retired & 32'h3));
        check("illegal_a", 32'(bus_a.illegal_op), 32'(ei));
        check("illegal_b", 32'(bus_b.illegal_op), 32'(ei));
        @(posedge clk);
        #1;
        if (ed) retired++;
    endtask

    task automatic do_reset();
        noise();
        mem_ready = 1'b1;
        reset     = 1'b1;
        retired   = 0;
        step(0, cw(0,0,1,0,0,0,0,0,0,2'b01,3'b000,0), 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    // zsel: 0/1 forces zero in BRANCH, 2 leaves it random
    task automatic run_instr(input int opc, input int zsel, input int fw, input int mw);
        logic pcw;
        bit   is_r;
        int   ms;
        is_r = (opc == 0);
        for (int i = 0; i < fw; i++) begin
            noise(); mem_ready = 1'b0;
            step(0, cw(0,0,1,0,0,0,0,0,0,2'b01,3'b000,0), 1'b0, 1'b0);
        end
        noise(); mem_ready = 1'b1;
        step(0, cw(1,0,1,0,1,0,0,0,0,2'b01,3'b000,0), 1'b0, 1'b0);
        noise(); opcode = 6'(opc);
        step(1, cw(0,0,0,0,0,0,0,0,0,2'b11,3'b000,0), opc > 9, 1'b0);
        if (opc > 9) return;
        noise();
        if (opc == 8 || opc == 9) begin
            step(2, cw(0,0,0,0,0,0,0,0,1,2'b10,3'b000,0), 1'b0, 1'b0);
            ms = (opc == 8) ? 3 : 5;
            for (int i = 0; i <= mw; i++) begin
                noise(); mem_ready = (i == mw);
                step(ms, cw(0,1,opc==8,opc==9,0,0,0,0,0,2'b00,3'b000,0),
                     (opc == 9) && (i == mw), 1'b0);
            end
            if (opc == 8) begin
                noise();
                step(4, cw(0,0,0,0,0,1,1,0,0,2'b00,3'b000,0), 1'b1, 1'b0);
            end
        end else if (opc == 5 || opc == 6) begin
            if (zsel < 2) zero = zsel[0];
            pcw = (opc == 5) ? zero : ~zero;
            step(8, cw(pcw,0,0,0,0,0,0,0,1,2'b00,3'b010,1), 1'b1, 1'b0);
        end else begin
            step(6, cw(0,0,0,0,0,0,0,0,1, is_r ? 2'b00 : 2'b10, exec_op[opc], 0), 1'b0, 1'b0);
            noise();
            step(7, cw(0,0,0,0,0,1,0,is_r,0,2'b00,3'b000,0), 1'b1, 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        int seq [0:4] = '{1, 2, 3, 0, 1};
        logic exp_done;
        int   exp_next;
        logic exp_ill;

        reset = 1'b1; opcode = 6'd0; zero = 1'b0; mem_ready = 1'b1;
        #1;
        do_reset();

        run_instr(8, 2, 0, 0);                  // lw: 0,1,2,3,4
        run_instr(0, 2, 0, 0);                  // R-type
        run_instr(3, 2, 0, 0);                  // ori
        run_instr(5, 1, 0, 0);                  // beq taken
        run_instr(6, 1, 0, 0);                  // bne not taken
        run_instr(9, 2, 0, 3);                  // sw with 3 stall cycles

`ifdef ILLEGAL_TRAP_EN
        noise(); mem_ready = 1'b1;
        step(0, cw(1,0,1,0,1,0,0,0,0,2'b01,3'b000,0), 1'b0, 1'b0);
        noise(); opcode = 6'd12;
        step(1, cw(0,0,0,0,0,0,0,0,0,2'b11,3'b000,0), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            noise();
            step(9, 15'd0, 1'b0, 1'b1);
        end
        do_reset();
`else
        run_instr(12, 2, 0, 0);
`endif

        for (int i = 0; i < 80; i++) begin
`ifdef ILLEGAL_TRAP_EN
            run_instr(int'($urandom_range(0, 9)), 2, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
`else
            run_instr(int'($urandom_range(0, 15)), 2, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
`endif
        end

        // Abort a load in MEMREAD while memory signals completion
        noise(); mem_ready = 1'b1;
        step(0, cw(1,0,1,0,1,0,0,0,0,2'b01,3'b000,0), 1'b0, 1'b0);
        noise(); opcode = 6'd8;
        step(1, cw(0,0,0,0,0,0,0,0,0,2'b11,3'b000,0), 1'b0, 1'b0);
        noise();
        step(2, cw(0,0,0,0,0,0,0,0,1,2'b10,3'b000,0), 1'b0, 1'b0);
        noise(); mem_ready = 1'b1;
        #1;
        reset = 1'b1;
        #1;
        check("abort_state_a",   32'(bus_a.state), 32'd0);
        check("abort_state_b",   32'(bus_b.state), 32'd0);
        check("abort_instret_a", 32'(bus_a.instret), 32'd0);
        check("abort_instret_b", 32'(bus_b.instret), 32'd0);
        retired = 0;
        step(0, cw(0,0,1,0,0,0,0,0,0,2'b01,3'b000,0), 1'b0, 1'b0);
        reset = 1'b0;
        noise(); mem_ready = 1'b0;
        step(0, cw(0,0,1,0,0,0,0,0,0,2'b01,3'b000,0), 1'b0, 1'b0);

        // Narrow counter wrap over five ALU instructions
        for (int i = 0; i < 5; i++) begin
            run_instr(1, 2, 0, 0);
            check("wrap_instret_b", 32'(bus_b.instret), 32'(seq[i]));
        end

        // Upper opcode bit set: illegal only for the 6-bit instance
`ifdef ILLEGAL_TRAP_EN
        exp_done = 1'b0; exp_next = 9; exp_ill = 1'b1;
`else
        exp_done = 1'b1; exp_next = 0; exp_ill = 1'b0;
`endif
        noise(); mem_ready = 1'b1;
        step(0, cw(1,0,1,0,1,0,0,0,0,2'b01,3'b000,0), 1'b0, 1'b0);
        noise(); opcode = 6'b010001;
        @(negedge clk);
        check("hiop_state_a", 32'(bus_a.state), 32'd1);
        check("hiop_done_a",  32'(bus_a.instr_done), 32'(exp_done));
        @(posedge clk);
        #1;
        check("hiop_next_a",    32'(bus_a.state), 32'(exp_next));
        check("hiop_illegal_a", 32'(bus_a.illegal_op), 32'(exp_ill));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mc_control_unit.md
# mc_control_unit

Multi-cycle MIPS control unit. A Moore-style FSM with a memory-ready handshake that sequences fetch, decode, execute, memory and write-back over several clocks. It drives the shared-memory multi-cycle datapath (PC, IR, A/B/ALUOut registers) and keeps the ALUOp encoding of the single-cycle decoder. It adds a parametrised opcode width, a retired-instruction counter and an optional illegal-opcode trap.

## Interface
- OPCODE_W, 4: opcode width, ≥4; any nonzero bit above [3] makes the opcode illegal
- CNT_W, 16: retired-instruction counter width
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- opcode  in  OPCODE_W  IR opcode field, valid from the DECODE cycle
- zero  in  1  ALU zero flag, sampled in BRANCH
- mem_ready  in  1  memory completes current read/write this cycle
- pc_write  out  1  PC load enable
- i_or_d  out  1  0 = PC addresses memory, 1 = ALUOut
- mem_read, mem_write  out  1 each  memory strobes
- ir_write  out  1  IR load enable
- reg_write, mem_to_reg, reg_dest  out  1 each  register-file controls
- alu_src_a  out  1  0 = PC, 1 = A
- alu_src_b  out  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = imm<<2
- alu_op  out  3  ALU operation
- pc_source  out  1  0 = ALU result, 1 = ALUOut
- state  out  4  current state encoding
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction
- instret  out  CNT_W  retired-instruction count
- illegal_op  out  1  sticky trap flag

## Operation
- Opcodes: R=0, addi=1, andi=2, ori=3, nori=4, beq=5, bne=6, slti=7, lw=8, sw=9; 10–15 illegal.
- EXEC alu_op: R=001, addi=000, andi=110, ori=111, nori=101, slti=100. BRANCH alu_op: beq/bne=010. MEMADDR alu_op: 000.
- States and encodings: FETCH=0, DECODE=1, MEMADDR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXEC=6, ALUWB=7, BRANCH=8, TRAP=9.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=000, pc_source=0.
  - ir_write and pc_write equal mem_ready.
  - Stays in FETCH until mem_ready=1, then goes to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=000 (computes the branch target).
  - Latches opcode into an internal register. All later states use the latched copy.
  - Next state: lw/sw→MEMADDR; R/I-type ALU ops→EXEC; beq/bne→BRANCH; illegal→see Configuration.
- MEMADDR: alu_src_a=1, alu_src_b=10, alu_op=000. Goes to MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: i_or_d=1, mem_read=1. Waits for mem_ready, then goes to MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dest=0. Goes to FETCH.
- MEMWRITE: i_or_d=1, mem_write=1. Waits for mem_ready, then goes to FETCH.
- EXEC: alu_src_a=1, alu_src_b=00 for R and 10 otherwise, alu_op per table. Goes to ALUWB.
- ALUWB: reg_write=1, mem_to_reg=0, reg_dest=1 only for R. Goes to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=010, pc_source=1.
  - pc_write = zero for beq, !zero for bne.
  - Goes to FETCH.
- Any output not listed for a state is 0.
- instr_done pulses in: MEMWB, ALUWB, BRANCH, MEMWRITE with mem_ready=1, and DECODE of an illegal opcode when the trap is compiled out.
- instret increments by 1 on every instr_done and wraps from 2^CNT_W−1 to 0.

## Timing
- Reset (asynchronous): state=FETCH, instret=0, illegal_op=0, latched opcode=0.
  - During reset all outputs are 0 except the FETCH Moore outputs: mem_read=1, alu_src_b=01.
  - pc_write and ir_write are held 0 while reset is high.
- Minimum latency with mem_ready tied high: branch 3 cycles, R/I-type 4, sw 4, lw 5. Each mem_ready=0 cycle in FETCH/MEMREAD/MEMWRITE adds 1 cycle.
- Mealy outputs (gated combinationally in the same cycle):
  - pc_write, ir_write by mem_ready in FETCH.
  - pc_write by zero in BRANCH.
  - instr_done by mem_ready in MEMWRITE.
- All other outputs depend only on state and the latched opcode.
- instret reflects the increment one cycle after the instr_done pulse.
- A change on opcode after DECODE has no effect on the current instruction.
- Reset asserted mid-instruction aborts it with no further strobes; instret is not incremented.

## Configuration
- ILLEGAL_TRAP_EN defined:
  - An illegal opcode in DECODE goes to TRAP.
  - TRAP drives every strobe 0, sets illegal_op=1, and stays in TRAP until reset.
  - No instr_done pulse.
- ILLEGAL_TRAP_EN undefined:
  - An illegal opcode executes as a NOP: DECODE→FETCH with an instr_done pulse, and instret increments.
  - TRAP is unreachable and illegal_op is tied 0.

## Test plan
- Reset mid-MEMREAD, mem_ready=1 → state=0 immediately; instret=0; no reg_write follows.
- lw (opcode 8), mem_ready high → state sequence 0,1,2,3,4; reg_write & mem_to_reg only in state 4; instret 0→1.
- R-type (0) then ori (3) → EXEC alu_op 001 then 111; alu_src_b 00 then 10; reg_dest 1 then 0.
- beq (5) with zero=1 and bne (6) with zero=1 → pc_write=1 and pc_write=0 respectively in BRANCH; 3 cycles each.
- sw (9) with mem_ready held low 3 cycles in MEMWRITE → mem_write high 4 cycles; instr_done on the mem_ready cycle only.
- Opcode 12 → with ILLEGAL_TRAP_EN: state=9, illegal_op=1 held over 10 cycles. Without it: back to FETCH, instret +1.
- CNT_W=2, five ALU instructions → instret 1,2,3,0,1.
